// File: rtl/regfile_mp.sv
// Multi-port register file with a dedicated PC register, write-to-read bypass,
// fixed write-port priority and a per-register busy scoreboard.

module regfile_mp_rd #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 16,
  parameter int AW        = 4,
  parameter int PC_INDEX  = 15,
  parameter int NUM_WRITE = 1,
  parameter int BYPASS    = 1
) (
  input  logic [AW-1:0]                   addr,
  input  logic [REG_COUNT-1:0][WIDTH-1:0] regs,
  input  logic [REG_COUNT-1:0]            busy,
  input  logic [WIDTH-1:0]                pc,
  input  logic                            bypass_en,
  input  logic [NUM_WRITE-1:0]            write_enable,
  input  logic [NUM_WRITE*AW-1:0]         write_addr,
  input  logic [NUM_WRITE*WIDTH-1:0]      write_value,
  output logic [WIDTH-1:0]                value,
  output logic                            busy_out
);
  localparam logic [AW-1:0] PCI = AW'(PC_INDEX);

  logic             hit;
  logic [WIDTH-1:0] bval;

  always_comb begin
    hit  = 1'b0;
    bval = '0;
    // Later ports overwrite earlier matches so the highest index wins, as in storage.
    if (BYPASS != 0 && bypass_en && addr != PCI) begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (write_enable[w] && write_addr[w*AW +: AW] == addr) begin
          hit  = 1'b1;
          bval = write_value[w*WIDTH +: WIDTH];
        end
      end
    end
    value    = (addr == PCI) ? pc : regs[addr];
    busy_out = busy[addr];
    if (hit) begin
      value    = bval;
      busy_out = 1'b0;
    end
  end
endmodule

module regfile_mp #(
  parameter int              WIDTH     = 32,
  parameter int              REG_COUNT = 16,
  parameter int              PC_INDEX  = 15,
  parameter int              NUM_READ  = 2,
  parameter int              NUM_WRITE = 1,
  parameter int              BYPASS    = 1,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  localparam int             AW        = $clog2(REG_COUNT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_READ*AW-1:0]     read_addr,
  output logic [NUM_READ*WIDTH-1:0]  read_value,
  output logic [NUM_READ-1:0]        read_busy,
  input  logic [NUM_WRITE-1:0]       write_enable,
  input  logic [NUM_WRITE*AW-1:0]    write_addr,
  input  logic [NUM_WRITE*WIDTH-1:0] write_value,
  input  logic                       reserve_enable,
  input  logic [AW-1:0]              reserve_addr,
  output logic [WIDTH-1:0]           pc,
  input  logic [WIDTH-1:0]           new_pc,
  input  logic                       update_pc
);
  localparam logic [AW-1:0] PCI = AW'(PC_INDEX);

  // Entry PC_INDEX of regs is never written; PC lives in its own register.
  logic [REG_COUNT-1:0][WIDTH-1:0] regs;
  logic [REG_COUNT-1:0]            busy;
  logic [NUM_READ-1:0][AW-1:0]     prev_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs      <= '0;
      busy      <= '0;
      prev_addr <= '0;
      pc        <= PC_RESET;
    end else begin
      prev_addr <= read_addr;
      if (update_pc) pc <= new_pc;
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (write_enable[w]) begin
          if (write_addr[w*AW +: AW] == PCI) pc <= write_value[w*WIDTH +: WIDTH];
          else regs[write_addr[w*AW +: AW]] <= write_value[w*WIDTH +: WIDTH];
          busy[write_addr[w*AW +: AW]] <= 1'b0;
        end
      end
      // A reservation on the same edge as a write marks a new producer, so it wins.
      if (reserve_enable && reserve_addr != PCI) busy[reserve_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    regfile_mp_rd #(
      .WIDTH(WIDTH), .REG_COUNT(REG_COUNT), .AW(AW), .PC_INDEX(PC_INDEX),
      .NUM_WRITE(NUM_WRITE), .BYPASS(BYPASS)
    ) u_rd (
      .addr        (prev_addr[i]),
      .regs        (regs),
      .busy        (busy),
      .pc          (pc),
      .bypass_en   (!reset),
      .write_enable(write_enable),
      .write_addr  (write_addr),
      .write_value (write_value),
      .value       (read_value[i*WIDTH +: WIDTH]),
      .busy_out    (read_busy[i])
    );
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NUM_READ; r++)
        assert (int'(read_addr[r*AW +: AW]) < REG_COUNT) else $error("read_addr %0d out of range", r);
      for (int w = 0; w < NUM_WRITE; w++)
        if (write_enable[w])
          assert (int'(write_addr[w*AW +: AW]) < REG_COUNT) else $error("write_addr %0d out of range", w);
      if (reserve_enable)
        assert (int'(reserve_addr) < REG_COUNT) else $error("reserve_addr out of range");
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, read latency, bypass, write priority,
// PC update priority, scoreboard and mid-stream reset.

module tb_regfile_mp;
  localparam int W = 32, RC = 16, PCI = 15, NR = 2, NW = 2, AW = 4;
  localparam logic [31:0] PCR = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR*AW-1:0] read_addr;
  logic [NR*W-1:0]  read_value;
  logic [NR-1:0]    read_busy;
  logic [NW-1:0]    write_enable;
  logic [NW*AW-1:0] write_addr;
  logic [NW*W-1:0]  write_value;
  logic             reserve_enable;
  logic [AW-1:0]    reserve_addr;
  logic [W-1:0]     pc, new_pc;
  logic             update_pc;

  int n_cmp = 0, n_err = 0;

  regfile_mp #(.WIDTH(W), .REG_COUNT(RC), .PC_INDEX(PCI), .NUM_READ(NR),
               .NUM_WRITE(NW), .BYPASS(1), .PC_RESET(PCR)) dut (
    .clk(clk), .reset(reset), .read_addr(read_addr), .read_value(read_value),
    .read_busy(read_busy), .write_enable(write_enable), .write_addr(write_addr),
    .write_value(write_value), .reserve_enable(reserve_enable),
    .reserve_addr(reserve_addr), .pc(pc), .new_pc(new_pc), .update_pc(update_pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    read_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] v);
    write_enable[p]         = 1'b1;
    write_addr[p*AW +: AW]  = a;
    write_value[p*W +: W]   = v;
  endtask

  task automatic clr();
    write_enable   = '0;
    reserve_enable = 1'b0;
    update_pc      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    n_cmp++; if (pc !== PCR) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, PCR); end
    n_cmp++; if (read_busy !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %b want 00", read_busy); end
    for (int r = 0; r < 15; r++) begin
      set_rd(0, AW'(r));
      step(); #1;
      n_cmp++; if (read_value[0 +: W] !== 32'h0) begin
        n_err++; $display("FAIL reset_read r%0d: got %h want 0", r, read_value[0 +: W]); end
      n_cmp++; if (read_busy[0] !== 1'b0) begin
        n_err++; $display("FAIL reset_rbusy r%0d: got %b want 0", r, read_busy[0]); end
    end
  endtask

  task automatic test_write_read();
    set_wr(0, 4'd3, 32'hDEADBEEF); set_rd(1, 4'd3);
    step(); clr(); #1;
    n_cmp++; if (read_value[W +: W] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL write_read: got %h want deadbeef", read_value[W +: W]); end
    // address r3 a cycle ahead, then write it; the write shows up before its edge
    set_wr(0, 4'd3, 32'hCAFEF00D); #1;
    n_cmp++; if (read_value[W +: W] !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL bypass: got %h want cafef00d", read_value[W +: W]); end
    step(); clr(); #1;
    n_cmp++; if (read_value[W +: W] !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL bypass_commit: got %h want cafef00d", read_value[W +: W]); end
  endtask

  task automatic test_priority();
    set_wr(0, 4'd5, 32'h11); set_wr(1, 4'd5, 32'h22); set_rd(0, 4'd5); set_rd(1, 4'd6);
    step(); clr(); #1;
    n_cmp++; if (read_value[0 +: W] !== 32'h22) begin
      n_err++; $display("FAIL wr_priority: got %h want 22", read_value[0 +: W]); end
    set_wr(0, 4'd6, 32'hAA); set_wr(1, 4'd6, 32'hBB); #1;
    n_cmp++; if (read_value[W +: W] !== 32'hBB) begin
      n_err++; $display("FAIL bypass_priority: got %h want bb", read_value[W +: W]); end
    step(); clr(); #1;
    n_cmp++; if (read_value[W +: W] !== 32'hBB) begin
      n_err++; $display("FAIL store_priority: got %h want bb", read_value[W +: W]); end
  endtask

  task automatic test_pc();
    set_wr(0, 4'(PCI), 32'h200); update_pc = 1'b1; new_pc = 32'h100; set_rd(0, 4'(PCI));
    step(); clr(); #1;
    n_cmp++; if (pc !== 32'h200) begin n_err++; $display("FAIL pc_write_wins: got %h want 200", pc); end
    n_cmp++; if (read_value[0 +: W] !== 32'h200) begin
      n_err++; $display("FAIL pc_read: got %h want 200", read_value[0 +: W]); end
    update_pc = 1'b1; new_pc = 32'h100;
    step(); clr(); #1;
    n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL pc_update: got %h want 100", pc); end
    set_wr(0, 4'(PCI), 32'h300); #1;
    n_cmp++; if (read_value[0 +: W] !== 32'h100) begin
      n_err++; $display("FAIL pc_no_bypass: got %h want 100", read_value[0 +: W]); end
    step(); clr(); #1;
    n_cmp++; if (pc !== 32'h300) begin n_err++; $display("FAIL pc_write: got %h want 300", pc); end
  endtask

  task automatic test_busy();
    reserve_enable = 1'b1; reserve_addr = 4'd7; set_rd(0, 4'd7);
    step(); clr(); #1;
    n_cmp++; if (read_busy[0] !== 1'b1) begin n_err++; $display("FAIL busy_set: got %b want 1", read_busy[0]); end
    set_wr(0, 4'd7, 32'h77); reserve_enable = 1'b1; reserve_addr = 4'd7; #1;
    n_cmp++; if (read_busy[0] !== 1'b0) begin n_err++; $display("FAIL busy_bypass: got %b want 0", read_busy[0]); end
    step(); clr(); #1;
    n_cmp++; if (read_busy[0] !== 1'b1) begin n_err++; $display("FAIL busy_reserve_wins: got %b want 1", read_busy[0]); end
    n_cmp++; if (read_value[0 +: W] !== 32'h77) begin
      n_err++; $display("FAIL busy_value: got %h want 77", read_value[0 +: W]); end
    set_wr(0, 4'd7, 32'h78);
    step(); clr(); #1;
    n_cmp++; if (read_busy[0] !== 1'b0) begin n_err++; $display("FAIL busy_clear: got %b want 0", read_busy[0]); end
    reserve_enable = 1'b1; reserve_addr = 4'(PCI); set_rd(1, 4'(PCI));
    step(); clr(); #1;
    n_cmp++; if (read_busy[1] !== 1'b0) begin n_err++; $display("FAIL busy_pc: got %b want 0", read_busy[1]); end
  endtask

  task automatic test_reset_mid();
    set_wr(0, 4'd2, 32'h55);
    step(); clr();
    reset = 1'b1; set_wr(0, 4'd4, 32'h66); update_pc = 1'b1; new_pc = 32'h777;
    reserve_enable = 1'b1; reserve_addr = 4'd4; set_rd(0, 4'd2); set_rd(1, 4'd4);
    step(); set_wr(0, 4'd0, 32'h99); #1;
    n_cmp++; if (read_value[0 +: W] !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_read: got %h want 0", read_value[0 +: W]); end
    n_cmp++; if (pc !== PCR) begin n_err++; $display("FAIL reset_mid_pc: got %h want %h", pc, PCR); end
    reset = 1'b0; clr();
    step(); #1;
    n_cmp++; if (read_value[0 +: W] !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_r2: got %h want 0", read_value[0 +: W]); end
    n_cmp++; if (read_value[W +: W] !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_r4: got %h want 0", read_value[W +: W]); end
    n_cmp++; if (read_busy[1] !== 1'b0) begin n_err++; $display("FAIL reset_mid_busy: got %b want 0", read_busy[1]); end
    n_cmp++; if (pc !== PCR) begin n_err++; $display("FAIL reset_mid_pc2: got %h want %h", pc, PCR); end
  endtask

  initial begin
    reset = 1'b1; read_addr = '0; write_addr = '0; write_value = '0;
    reserve_addr = '0; new_pc = '0;
    clr();
    test_reset();
    test_write_read();
    test_priority();
    test_pc();
    test_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
